carry_chain_adder: RTL and testbench
====================================

Name: carry_chain_adder

Overview:
- Registered, handshaked successor to the combinational full_adder for CGRA tile datapaths.
- Adds or subtracts WIDTH-bit words with a valid/ready interface.
- Chains carries across consecutive beats so wide operands stream through low word first.
- Supports accumulate mode and the existing carry_listen / on_off controls; sits between the tile operand routers and the tile output register.

Parameters:
- WIDTH, 8, datapath word width in bits (>=2).
- ACC_INIT, 0, reset/clear value of the accumulator register (WIDTH bits).

Ports:
- clk  input  1  tile clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- on_off  input  1  block enable; 0 = gated off.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored in ACC ops.
- op  input  2  00 ADD, 01 SUB, 10 ACC_ADD, 11 ACC_LOAD.
- carry_in  input  1  external carry for the first word of a chain.
- carry_listen  input  1  1 = first-word carry comes from carry_in; 0 = internal default.
- chain_last  input  1  beat is the final (most significant) word of its chain.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- c  output  WIDTH  result word.
- carry_out  output  1  carry out of the result word; for SUB, 1 = no borrow.

Behaviour:
- Reset: rst_n is asynchronous and active-low. On assertion: out_valid=0, c=0, carry_out=0, chain FSM=IDLE, carry_reg=0, acc_reg=ACC_INIT. Applies immediately, including mid-chain; any partially processed chain is discarded.
- Handshake:
  - in_ready = on_off & (~out_valid_q | out_ready).
  - A beat is accepted when in_valid & in_ready.
  - Latency is 1 cycle: the result is registered on the accepting edge.
  - out_valid clears on out_valid & out_ready with no new accept; back-to-back throughput is 1 beat/cycle.
  - While out_valid=1 and out_ready=0, c and carry_out hold stable.
- Chain FSM:
  - States: IDLE (next beat is the first word) and CHAIN (mid-operand).
  - IDLE -> CHAIN on an accepted beat with chain_last=0.
  - CHAIN -> IDLE on an accepted beat with chain_last=1.
  - Otherwise the state holds.
  - An accepted beat in IDLE with chain_last=1 is a single-word op and stays IDLE.
- Carry source per accepted beat:
  - In CHAIN: carry_reg.
  - In IDLE with carry_listen=1: carry_in.
  - In IDLE with carry_listen=0: 1 for SUB, 0 for all other ops.
- Arithmetic (WIDTH+1-bit sum; the MSB is carry_out):
  - ADD: a + b + cy.
  - SUB: a + ~b + cy.
  - ACC_ADD: a + acc_reg + cy.
  - ACC_LOAD: c = a, carry_out = 0, carry_reg = 0; no addition.
- Register updates on accept:
  - carry_reg <= carry_out if chain_last=0, else 0.
  - acc_reg <= the new c for every op.
- Op changes mid-chain are legal; each word uses its own op and the chained carry.
- on_off=0:
  - in_ready=0; c and carry_out are driven 0 and out_valid is forced 0 at the outputs.
  - All internal registers (result, out_valid_q, FSM, carry_reg, acc_reg) hold.
  - On return to 1, a pending result reappears unchanged.
  - out_ready is ignored while off.
- Simultaneous accept and output drain in the same cycle: the new result replaces the old one and out_valid stays 1.

Optional Feature:
- Macro: CARRY_CHAIN_ADDER_SAT_EN.
- When defined, unsigned saturation applies on accepted beats with chain_last=1 and op ADD or ACC_ADD:
  - If the sum carries out, c = all ones and carry_out = 1.
  - SUB with borrow (carry_out = 0) gives c = 0.
  - acc_reg stores the saturated value.
  - Non-final chain words are never saturated.
- When undefined: results wrap modulo 2^WIDTH and no saturation logic is present.

Test Plan (WIDTH=8):
- Reset mid-chain: after one accepted beat with chain_last=0, pulse rst_n low without a clock edge -> out_valid=0, c=0, carry_out=0 immediately; the next beat is treated as IDLE.
- Single word: ADD a=5, b=10, carry_listen=1, carry_in=0 -> next cycle c=15, carry_out=0. Then a=150, b=10, carry_in=1 -> c=161. Then a=200, b=100, carry_listen=0 -> c=44, carry_out=1.
- SUB, carry_listen=0: a=10, b=3 -> c=7, carry_out=1. a=3, b=10 -> c=249, carry_out=0.
- Two-word chain 0x01FF+0x0001: beat1 a=0xFF, b=0x01, chain_last=0 -> c=0x00, carry_out=1. Beat2 a=0x01, b=0x00, chain_last=1 -> c=0x02, carry_out=0. With SAT_EN, a single-word 200+100 -> c=255.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and c stable. Release -> the held result drains and the next beat is accepted the same cycle.
- on_off=0 with a pending result c=15 -> c=0, out_valid=0, in_ready=0. Set on_off=1 -> c=15, out_valid=1. ACC_LOAD a=7 then ACC_ADD a=5 -> c=12.

Source files
------------

// File: rtl/carry_chain_adder.sv
// Registered add/sub/accumulate stage with carry chaining across beats and a valid/ready handshake.
// Optional unsigned saturation on final chain words: define CARRY_CHAIN_ADDER_SAT_EN.
module carry_chain_adder #(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             on_off,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             carry_in,
    input  logic             carry_listen,
    input  logic             chain_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry_out
);

    localparam logic [1:0] OP_ADD      = 2'b00;
    localparam logic [1:0] OP_SUB      = 2'b01;
    localparam logic [1:0] OP_ACC_ADD  = 2'b10;
    localparam logic [1:0] OP_ACC_LOAD = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHAIN = 1'b1
    } chain_state_t;

    chain_state_t     state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             cout_q, cout_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             accept;
    logic             drain;
    logic             cy;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_c;
    logic             res_co;

    // While gated off nothing is accepted or drained, so every register holds.
    assign in_ready = on_off & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign drain    = on_off & out_valid_q & out_ready;

    always_comb begin
        cy = 1'b0;
        if (state_q == ST_CHAIN) begin
            cy = carry_q;
        end else if (carry_listen) begin
            cy = carry_in;
        end else begin
            cy = (op == OP_SUB);
        end
    end

    always_comb begin
        opb = '0;
        case (op)
            OP_ADD:      opb = b;
            OP_SUB:      opb = ~b;
            OP_ACC_ADD:  opb = acc_q;
            OP_ACC_LOAD: opb = '0;
            default:     opb = '0;
        endcase
        sum    = {1'b0, a} + {1'b0, opb} + {{WIDTH{1'b0}}, cy};
        res_c  = sum[WIDTH-1:0];
        res_co = sum[WIDTH];
        if (op == OP_ACC_LOAD) begin
            res_c  = a;
            res_co = 1'b0;
        end
`ifdef CARRY_CHAIN_ADDER_SAT_EN
        // Only the most significant word of a chain clamps; lower words must wrap to stay exact.
        if (chain_last) begin
            if ((op == OP_ADD || op == OP_ACC_ADD) && sum[WIDTH]) begin
                res_c  = '1;
                res_co = 1'b1;
            end else if (op == OP_SUB && !sum[WIDTH]) begin
                res_c = '0;
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        c_d         = c_q;
        cout_d      = cout_q;
        carry_d     = carry_q;
        acc_d       = acc_q;
        if (accept) begin
            out_valid_d = 1'b1;
            c_d         = res_c;
            cout_d      = res_co;
            carry_d     = chain_last ? 1'b0 : res_co;
            acc_d       = res_c;
            state_d     = chain_last ? ST_IDLE : ST_CHAIN;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            cout_q      <= 1'b0;
            carry_q     <= 1'b0;
            acc_q       <= ACC_INIT;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            cout_q      <= cout_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = on_off & out_valid_q;
    assign c         = on_off ? c_q : '0;
    assign carry_out = on_off & cout_q;

endmodule

// File: tb/tb_carry_chain_adder.sv
// Directed bench for carry_chain_adder (WIDTH=8): vector table plus reset, backpressure and gating sequences.
module tb_carry_chain_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       on_off;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       carry_in;
    logic       carry_listen;
    logic       chain_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] c;
    logic       carry_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    carry_chain_adder #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .on_off       (on_off),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .op           (op),
        .carry_in     (carry_in),
        .carry_listen (carry_listen),
        .chain_last   (chain_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .c            (c),
        .carry_out    (carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       listen;
        logic       last;
        logic [7:0] exp_c;
        logic       exp_co;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
            $display("check %-16s got %0d ok", name, act);
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic beat(input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb,
                        input logic cin, input logic listen, input logic last);
        @(negedge clk);
        op           = o;
        a            = va;
        b            = vb;
        carry_in     = cin;
        carry_listen = listen;
        chain_last   = last;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // op, a, b, cin, listen, last, exp_c, exp_co
        vecs[0]  = '{2'b00, 8'd5,   8'd10,  1'b0, 1'b1, 1'b1, 8'd15,  1'b0};
        vecs[1]  = '{2'b00, 8'd150, 8'd10,  1'b1, 1'b1, 1'b1, 8'd161, 1'b0};
`ifdef CARRY_CHAIN_ADDER_SAT_EN
        vecs[2]  = '{2'b00, 8'd200, 8'd100, 1'b0, 1'b0, 1'b1, 8'd255, 1'b1};
`else
        vecs[2]  = '{2'b00, 8'd200, 8'd100, 1'b0, 1'b0, 1'b1, 8'd44,  1'b1};
`endif
        vecs[3]  = '{2'b01, 8'd10,  8'd3,   1'b0, 1'b0, 1'b1, 8'd7,   1'b1};
`ifdef CARRY_CHAIN_ADDER_SAT_EN
        vecs[4]  = '{2'b01, 8'd3,   8'd10,  1'b0, 1'b0, 1'b1, 8'd0,   1'b0};
`else
        vecs[4]  = '{2'b01, 8'd3,   8'd10,  1'b0, 1'b0, 1'b1, 8'd249, 1'b0};
`endif
        // 0x01FF + 0x0001, low word first
        vecs[5]  = '{2'b00, 8'hFF,  8'h01,  1'b0, 1'b0, 1'b0, 8'h00,  1'b1};
        vecs[6]  = '{2'b00, 8'h01,  8'h00,  1'b0, 1'b0, 1'b1, 8'h02,  1'b0};
        vecs[7]  = '{2'b11, 8'd7,   8'd99,  1'b0, 1'b0, 1'b1, 8'd7,   1'b0};
        vecs[8]  = '{2'b10, 8'd5,   8'd99,  1'b0, 1'b0, 1'b1, 8'd12,  1'b0};
        // 0x0100 - 0x0001 = 0x00FF
        vecs[9]  = '{2'b01, 8'h00,  8'h01,  1'b0, 1'b0, 1'b0, 8'hFF,  1'b0};
        vecs[10] = '{2'b01, 8'h01,  8'h00,  1'b0, 1'b0, 1'b1, 8'h00,  1'b1};
        // op change mid-chain: ADD low word, ACC_ADD high word using acc=0 and chained carry
        vecs[11] = '{2'b00, 8'h80,  8'h80,  1'b0, 1'b0, 1'b0, 8'h00,  1'b1};
        vecs[12] = '{2'b10, 8'h03,  8'h00,  1'b0, 1'b0, 1'b1, 8'h04,  1'b0};

        rst_n = 1'b0; on_off = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0; carry_in = 1'b0; carry_listen = 1'b0; chain_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_c", int'(c), 0);
        check("rst_carry_out", int'(carry_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            beat(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].listen, vecs[i].last);
            check($sformatf("v%0d_c", i), int'(c), int'(vecs[i].exp_c));
            check($sformatf("v%0d_co", i), int'(carry_out), int'(vecs[i].exp_co));
            check($sformatf("v%0d_valid", i), int'(out_valid), 1);
        end
        @(negedge clk);
        in_valid = 1'b0;

        // reset mid-chain, asynchronously between edges
        beat(2'b00, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("mid_pre_co", int'(carry_out), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_c", int'(c), 0);
        check("mid_rst_co", int'(carry_out), 0);
        #1 rst_n = 1'b1;
        beat(2'b00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
        check("post_rst_idle_c", int'(c), 1);

        // backpressure
        beat(2'b00, 8'd5, 8'd10, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        a = 8'd1; b = 8'd1; carry_listen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_in_ready", k), int'(in_ready), 0);
            check($sformatf("bp%0d_c", k), int'(c), 15);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_rel_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        check("bp_next_c", int'(c), 2);
        check("bp_next_valid", int'(out_valid), 1);

        // on_off gating with a pending result
        beat(2'b00, 8'd5, 8'd10, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        on_off = 1'b0;
        #1;
        check("off_c", int'(c), 0);
        check("off_valid", int'(out_valid), 0);
        check("off_in_ready", int'(in_ready), 0);
        out_ready = 1'b1; in_valid = 1'b1; a = 8'd77;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; on_off = 1'b1;
        #1;
        check("on_c", int'(c), 15);
        check("on_valid", int'(out_valid), 1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain_valid", int'(out_valid), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
